// File: rtl/trace_capture_buffer.sv
// trace_capture_buffer: circular capture of {pc, inst, wb} snapshots around a
// trigger, frozen after POST_TRIG further entries, then read out oldest-first.
// Optional per-entry timestamp under macro TRACE_TIMESTAMP_EN (adds TS_W, rd_ts).
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE 00 | no capture; waiting for arm
// ARMED 01| pre-trigger capture, oldest entries overwritten once full
// POST 10 | post-trigger capture, `remaining` counts down per write
// DONE 11 | buffer frozen; rd_req pops entries oldest-first
module trace_capture_buffer #(
  parameter int PC_W      = 32,
  parameter int INST_W    = 32,
  parameter int WB_W      = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8
`ifdef TRACE_TIMESTAMP_EN
  , parameter int TS_W    = 16
`endif
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    cap_valid,
  input  logic [PC_W-1:0]         cap_pc,
  input  logic [INST_W-1:0]       cap_inst,
  input  logic [WB_W-1:0]         cap_wb,
  input  logic                    arm,
  input  logic                    trig,
  input  logic                    rd_req,
  output logic                    rd_valid,
  output logic [PC_W-1:0]         rd_pc,
  output logic [INST_W-1:0]       rd_inst,
  output logic [WB_W-1:0]         rd_wb,
  output logic                    rd_last,
  output logic [1:0]              state,
  output logic [$clog2(DEPTH):0]  count
`ifdef TRACE_TIMESTAMP_EN
  , output logic [TS_W-1:0]       rd_ts
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("trace_capture_buffer: DEPTH must be a power of two >= 2");
  end
  if (POST_TRIG < 0 || POST_TRIG > DEPTH - 1) begin : g_bad_post
    $error("trace_capture_buffer: POST_TRIG must be in 0..DEPTH-1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARMED = 2'b01,
    S_POST  = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t          st_q, st_d;
  logic            wr_en, rd_fire, rd_final;
  logic [AW-1:0]   wptr, raddr;
  logic [CW-1:0]   cnt, remaining, rd_cnt;

  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [WB_W-1:0]   wb_mem   [DEPTH];

  // Oldest entry sits count slots behind the write pointer; rd_cnt walks forward from it.
  assign raddr    = wptr - cnt[AW-1:0] + rd_cnt[AW-1:0];
  assign rd_final = (rd_cnt + CW'(1)) == cnt;
  assign state    = st_q;
  assign count    = cnt;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) st_q <= S_IDLE;
    else     st_q <= st_d;
  end

  // Next-state decode plus write/read strobes; arm always wins.
  always_comb begin
    st_d    = st_q;
    wr_en   = 1'b0;
    rd_fire = 1'b0;
    unique case (st_q)
      S_IDLE: begin
        if (arm) st_d = S_ARMED;
      end
      S_ARMED: begin
        if (arm) st_d = S_ARMED;
        else begin
          wr_en = cap_valid;
          if (trig) st_d = (POST_TRIG == 0) ? S_DONE : S_POST;
        end
      end
      S_POST: begin
        if (arm) st_d = S_ARMED;
        else begin
          wr_en = cap_valid;
          if (cap_valid && remaining == CW'(1)) st_d = S_DONE;
        end
      end
      S_DONE: begin
        if (arm) st_d = S_ARMED;
        else if (rd_req && rd_cnt < cnt) begin
          rd_fire = 1'b1;
          if (rd_final) st_d = S_IDLE;
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  // Pointers, occupancy, post-trigger countdown and registered read port.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr      <= '0;
      cnt       <= '0;
      remaining <= '0;
      rd_cnt    <= '0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      rd_pc     <= '0;
      rd_inst   <= '0;
      rd_wb     <= '0;
    end else begin
      rd_valid <= rd_fire;
      rd_last  <= rd_fire && rd_final;
      if (rd_fire) begin
        rd_pc   <= pc_mem[raddr];
        rd_inst <= inst_mem[raddr];
        rd_wb   <= wb_mem[raddr];
        rd_cnt  <= rd_cnt + CW'(1);
      end
      if (arm) begin
        wptr      <= '0;
        cnt       <= '0;
        rd_cnt    <= '0;
        remaining <= '0;
      end else begin
        if (wr_en) begin
          wptr <= wptr + AW'(1);
          if (cnt != CW'(DEPTH)) cnt <= cnt + CW'(1);
        end
        if (st_q == S_ARMED && trig)      remaining <= CW'(POST_TRIG);
        else if (st_q == S_POST && wr_en) remaining <= remaining - CW'(1);
      end
    end
  end

  // Snapshot storage; contents are not cleared by reset.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      pc_mem[wptr]   <= cap_pc;
      inst_mem[wptr] <= cap_inst;
      wb_mem[wptr]   <= cap_wb;
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_ctr;
  logic [TS_W-1:0] ts_mem [DEPTH];

  // Free-running cycle counter; wraps naturally.
  always_ff @(posedge CLK) begin
    if (RST) ts_ctr <= '0;
    else     ts_ctr <= ts_ctr + TS_W'(1);
  end

  // Timestamp stored alongside each snapshot.
  always_ff @(posedge CLK) begin
    if (wr_en) ts_mem[wptr] <= ts_ctr;
  end

  // Timestamp read port, aligned with the other read fields.
  always_ff @(posedge CLK) begin
    if (RST)          rd_ts <= '0;
    else if (rd_fire) rd_ts <= ts_mem[raddr];
  end
`endif

endmodule
